// File: rtl/frame_ctrl.sv
// Frame sequencer: pulls pixels from a ready/valid source, retimes them into a
// registered output stage with sof/eol/eof and row/col tags, and runs N frames or continuously.
module frame_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned VBLANK = 4,
  parameter int unsigned FCNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [FCNT_W-1:0]         num_frames,
  input  logic [7:0]                src_pixel,
  input  logic                      src_valid,
  output logic                      src_ready,
  output logic [7:0]                pix_out,
  output logic                      pix_valid,
  input  logic                      sink_ready,
  output logic                      sof,
  output logic                      eol,
  output logic                      eof,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic                      busy,
  output logic                      done,
  output logic [FCNT_W-1:0]         frames_done
);

  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned VB_W  = (VBLANK > 1) ? $clog2(VBLANK) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_VBLANK, S_FLUSH, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] nf_q, nf_d;
  logic [FCNT_W-1:0] frames_done_q, frames_done_d;
  logic              stop_pend_q, stop_pend_d;
  logic [ROW_W-1:0]  pos_row_q, pos_row_d;
  logic [COL_W-1:0]  pos_col_q, pos_col_d;
  logic [VB_W-1:0]   vb_cnt_q, vb_cnt_d;
  logic [7:0]        pix_out_q, pix_out_d;
  logic              pix_valid_q, pix_valid_d;
  logic              sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              last_col, last_row;
  logic [FCNT_W-1:0] frames_inc;

  assign src_ready  = (state_q == S_RUN) & (!pix_valid_q | sink_ready);
  assign accept     = src_valid & src_ready;
  assign last_col   = (pos_col_q == COL_W'(WIDTH - 1));
  assign last_row   = (pos_row_q == ROW_W'(HEIGHT - 1));
  assign frames_inc = FCNT_W'(frames_done_q + 1'b1);

  // Next-state, position counter and output-stage logic
  always_comb begin
    state_d       = state_q;
    nf_d          = nf_q;
    frames_done_d = frames_done_q;
    stop_pend_d   = stop_pend_q;
    pos_row_d     = pos_row_q;
    pos_col_d     = pos_col_q;
    vb_cnt_d      = vb_cnt_q;
    pix_out_d     = pix_out_q;
    pix_valid_d   = pix_valid_q;
    sof_d         = sof_q;
    eol_d         = eol_q;
    eof_d         = eof_q;
    row_d         = row_q;
    col_d         = col_q;
    done_d        = 1'b0;

    // Output stage drains in every state; it only loads in RUN
    if (accept) begin
      pix_out_d   = src_pixel;
      pix_valid_d = 1'b1;
      sof_d       = (pos_row_q == '0) && (pos_col_q == '0);
      eol_d       = last_col;
      eof_d       = last_col && last_row;
      row_d       = pos_row_q;
      col_d       = pos_col_q;
    end else if (sink_ready) begin
      pix_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nf_d          = num_frames;
          frames_done_d = '0;
          stop_pend_d   = 1'b0;
          pos_row_d     = '0;
          pos_col_d     = '0;
          row_d         = '0;
          col_d         = '0;
          state_d       = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (accept) begin
          pos_col_d = last_col ? '0 : COL_W'(pos_col_q + 1'b1);
          if (last_col) pos_row_d = last_row ? '0 : ROW_W'(pos_row_q + 1'b1);
          if (last_col && last_row) begin
            frames_done_d = frames_inc;
            if (stop_pend_q || stop || ((nf_q != '0) && (frames_inc == nf_q))) begin
              state_d = S_FLUSH;
            end else if (VBLANK > 0) begin
              vb_cnt_d = '0;
              state_d  = S_VBLANK;
            end
          end
        end
      end
      S_VBLANK: begin
        if (stop) stop_pend_d = 1'b1;
        vb_cnt_d = VB_W'(vb_cnt_q + 1'b1);
        if (vb_cnt_q == VB_W'(VBLANK - 1)) begin
          state_d = (stop_pend_q || stop) ? S_FLUSH : S_RUN;
        end
      end
      S_FLUSH: begin
        if (!pix_valid_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      nf_q          <= '0;
      frames_done_q <= '0;
      stop_pend_q   <= 1'b0;
      pos_row_q     <= '0;
      pos_col_q     <= '0;
      vb_cnt_q      <= '0;
      pix_out_q     <= '0;
      pix_valid_q   <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      eof_q         <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nf_q          <= nf_d;
      frames_done_q <= frames_done_d;
      stop_pend_q   <= stop_pend_d;
      pos_row_q     <= pos_row_d;
      pos_col_q     <= pos_col_d;
      vb_cnt_q      <= vb_cnt_d;
      pix_out_q     <= pix_out_d;
      pix_valid_q   <= pix_valid_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      eof_q         <= eof_d;
      row_q         <= row_d;
      col_q         <= col_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pix_out     = pix_out_q;
  assign pix_valid   = pix_valid_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign eof         = eof_q;
  assign row         = row_q;
  assign col         = col_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Directed bench for frame_ctrl: a scoreboard queue holds the expected pixel and
// tags for every accepted source pixel and is checked as the sink consumes them.
module tb_frame_ctrl;

  localparam int unsigned W      = 8;
  localparam int unsigned H      = 8;
  localparam int unsigned VB     = 4;
  localparam int unsigned FW     = 8;
  localparam int unsigned ROW_W  = $clog2(H);
  localparam int unsigned COL_W  = $clog2(W);
  localparam int unsigned TW     = 11 + ROW_W + COL_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [FW-1:0]     num_frames = '0;
  logic [7:0]        src_pixel = '0;
  logic              src_valid = 1'b0;
  logic              src_ready;
  logic [7:0]        pix_out;
  logic              pix_valid;
  logic              sink_ready = 1'b0;
  logic              sof, eol, eof;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              busy, done;
  logic [FW-1:0]     frames_done;

  frame_ctrl #(.WIDTH(W), .HEIGHT(H), .VBLANK(VB), .FCNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_frames(num_frames),
    .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
    .pix_out(pix_out), .pix_valid(pix_valid), .sink_ready(sink_ready),
    .sof(sof), .eol(eol), .eof(eof), .row(row), .col(col),
    .busy(busy), .done(done), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int            nvec = 0;
  int            nerr = 0;
  logic [TW-1:0] sb[$];
  logic [7:0]    pix_seq = 8'h00;
  int            m_row = 0;
  int            m_col = 0;
  int            run_acc = 0;
  int            done_cnt = 0;
  int            gap = 0;
  bit            after_eof = 1'b0;
  bit            chk_gap = 1'b0;
  logic          s_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check/score 1 time unit later, then wait for posedge
  task automatic cyc(input logic sv, input logic sr, input logic st, input logic sp);
    logic [TW-1:0] exp_v;
    logic [TW-1:0] obs_v;
    bit            is_eof;
    @(negedge clk);
    src_valid = sv; sink_ready = sr; start = st; stop = sp; src_pixel = pix_seq;
    #1;
    s_ready = src_ready;
    chk("valid_vs_sb", 32'(pix_valid), 32'(sb.size() != 0));
    if (pix_valid && sb.size() != 0) begin
      obs_v = {pix_out, sof, eol, eof, row, col};
      chk("pixel_tags", 32'(obs_v), 32'(sb[0]));
    end
    if (done) begin
      done_cnt++;
      chk("drained_at_done", 32'(sb.size()), 32'd0);
    end
    if (pix_valid && sink_ready && sb.size() != 0) void'(sb.pop_front());
    if (after_eof && !src_ready) gap++;
    if (src_valid && src_ready) begin
      if (after_eof && chk_gap) chk("vblank_gap", 32'(gap), 32'(VB));
      after_eof = 1'b0;
      is_eof = (m_col == W - 1) && (m_row == H - 1);
      exp_v = {pix_seq, 1'b0, 1'b0, 1'b0, ROW_W'(m_row), COL_W'(m_col)};
      exp_v[COL_W+ROW_W+2] = (m_row == 0) && (m_col == 0);
      exp_v[COL_W+ROW_W+1] = (m_col == W - 1);
      exp_v[COL_W+ROW_W]   = is_eof;
      sb.push_back(exp_v);
      if (is_eof) begin after_eof = 1'b1; gap = 0; end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
      pix_seq = 8'(pix_seq + 8'd1);
      run_acc++;
    end
    @(posedge clk);
  endtask

  // stop_at: -1 none, 0 together with start, >0 once that many pixels are accepted
  task automatic run_frames(input logic [FW-1:0] nf, input int vmode, input int rmode,
                            input int stop_at, input int restart_at, input int abort_at);
    int   budget;
    bit   stopped, restarted;
    logic sv, sr, st, sp;
    m_row = 0; m_col = 0; run_acc = 0; done_cnt = 0; after_eof = 1'b0;
    chk_gap = (rmode == 0); stopped = 1'b0; restarted = 1'b0;
    num_frames = nf;
    cyc(1'b0, 1'b1, 1'b1, 1'(stop_at == 0));
    budget = 0;
    while (done_cnt == 0 && budget < 4000) begin
      if (abort_at >= 0 && run_acc == abort_at) return;
      sv = (vmode == 0) ? 1'b1 : 1'(budget % 4 == 0);
      sr = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      st = 1'b0; sp = 1'b0;
      if (restart_at >= 0 && run_acc == restart_at && !restarted) begin
        st = 1'b1; num_frames = 8'd5; restarted = 1'b1;
      end
      if (stop_at > 0 && run_acc == stop_at && !stopped) begin
        sp = 1'b1; stopped = 1'b1;
      end
      cyc(sv, sr, st, sp);
      budget++;
    end
    chk("run_done_seen", 32'(done_cnt != 0), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_after_run", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; src_valid = 1'b0; sink_ready = 1'b0; start = 1'b0; stop = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pix_out", 32'(pix_out), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_tags", 32'({sof, eol, eof}), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frames_done", 32'(frames_done), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    sb.delete();
    after_eof = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // Two frames, full throughput
    run_frames(8'd2, 0, 0, -1, -1, -1);
    chk("t1_accepts", 32'(run_acc), 32'd128);
    chk("t1_frames_done", 32'(frames_done), 32'd2);

    // Two frames, random sink back-pressure
    run_frames(8'd2, 0, 1, -1, -1, -1);
    chk("t2_accepts", 32'(run_acc), 32'd128);
    chk("t2_frames_done", 32'(frames_done), 32'd2);

    // Continuous run, stop during frame 3
    run_frames(8'd0, 0, 0, 148, -1, -1);
    chk("t3_accepts", 32'(run_acc), 32'd192);
    chk("t3_frames_done", 32'(frames_done), 32'd3);
    repeat (5) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_idle_src_ready", 32'(s_ready), 32'd0);
    end

    // Sparse source
    run_frames(8'd1, 1, 0, -1, -1, -1);
    chk("t4_accepts", 32'(run_acc), 32'd64);
    chk("t4_frames_done", 32'(frames_done), 32'd1);

    // Reset mid-frame, then a clean restart
    run_frames(8'd1, 0, 0, -1, -1, 30);
    do_reset();
    run_frames(8'd1, 0, 0, -1, -1, -1);
    chk("t5_accepts", 32'(run_acc), 32'd64);
    chk("t5_frames_done", 32'(frames_done), 32'd1);

    // start while busy is ignored
    run_frames(8'd1, 0, 0, -1, 10, -1);
    chk("t6_accepts", 32'(run_acc), 32'd64);
    chk("t6_frames_done", 32'(frames_done), 32'd1);
    // stop in IDLE is ignored
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_src_ready", 32'(s_ready), 32'd0);
    chk("t6_idle_frames_hold", 32'(frames_done), 32'd1);
    // start and stop together: start wins, both frames run
    run_frames(8'd2, 0, 0, 0, -1, -1);
    chk("t6_ss_accepts", 32'(run_acc), 32'd128);
    chk("t6_ss_frames_done", 32'(frames_done), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/frame_ctrl.md
Name: frame_ctrl

Overview:
Frame sequencer between the pixel source (test-pattern generator or file reader) and the Sobel window/line-buffer datapath. On a start command it runs a programmed number of frames, or runs continuously until stopped. It pulls pixels from the source with a ready/valid handshake and re-times them into a registered output stage. It tags each output pixel with sof/eol/eof and row/col coordinates, inserts a vertical-blank gap between frames, and reports busy/done status.

Parameters:
WIDTH, 8, pixels per line (>=2)
HEIGHT, 8, lines per frame (>=2)
VBLANK, 4, idle cycles inserted between frames (0 allowed)
FCNT_W, 8, width of frame count/status counters

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  1-cycle pulse; begin a run (ignored unless IDLE)
stop  in  1  1-cycle pulse; finish current frame then end run
num_frames  in  FCNT_W  frames per run, sampled on start; 0 = continuous
src_pixel  in  8  source pixel
src_valid  in  1  source pixel valid
src_ready  out  1  controller accepts source pixel this cycle
pix_out  out  8  pixel to Sobel datapath
pix_valid  out  1  pix_out valid
sink_ready  in  1  datapath accepts pix_out this cycle
sof  out  1  pix_out is row 0, col 0
eol  out  1  pix_out is col WIDTH-1
eof  out  1  pix_out is row HEIGHT-1, col WIDTH-1
row  out  clog2(HEIGHT)  row of pix_out
col  out  clog2(WIDTH)  col of pix_out
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at end of run
frames_done  out  FCNT_W  frames fully accepted this run

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. pix_out=0, pix_valid=0, sof/eol/eof=0, row=col=0, busy=0, done=0, frames_done=0, internal counters and the stop_pending flag cleared. Reset overrides every other input, including mid-frame; the partial frame is discarded.
- States: IDLE, RUN, VBLANK, FLUSH, DONE.
- IDLE: src_ready=0. start=1 latches num_frames, clears frames_done/row/col/stop_pending, moves to RUN.
- RUN: src_ready = !pix_valid | sink_ready (combinational).
  - Accept = src_valid & src_ready. On accept, next cycle: pix_out=src_pixel, pix_valid=1, and tags/row/col reflect the accepted pixel's position. Latency 1 cycle.
  - If not accepting and sink_ready=1, pix_valid clears. pix_valid=1 with sink_ready=0 holds pix_out and tags stable (no drop, no duplicate).
  - Position counter advances per accept: col wraps WIDTH-1 -> 0 and increments row; row wraps HEIGHT-1 -> 0.
  - Accepting the eof pixel increments frames_done (wraps modulo 2^FCNT_W).
    - If stop_pending, or num_frames!=0 and the new frames_done==num_frames: go to FLUSH.
    - Else if VBLANK>0: go to VBLANK.
    - Else: stay in RUN. Back-to-back frames are allowed.
- VBLANK: src_ready=0. The output stage still drains on sink_ready. Count VBLANK cycles, then return to RUN.
- FLUSH: src_ready=0. Wait for pix_valid=0, i.e. the last pixel consumed; then DONE.
- DONE: done=1 for exactly 1 cycle, then IDLE. frames_done holds its value until the next start.
- stop: sampled in RUN/VBLANK and sets stop_pending.
  - The current frame always completes; no partial frames reach the datapath.
  - stop in VBLANK goes to FLUSH at the end of the blank.
  - stop in IDLE/FLUSH/DONE is ignored.
- start while busy=1 is ignored. start and stop in the same IDLE cycle: start wins, stop is ignored.
- A run with num_frames=1 ends after exactly WIDTH*HEIGHT accepts.

Test Plan:
- Reset, then start with num_frames=2, src_valid=1, sink_ready=1 -> 64 pixels out with 1-cycle latency. sof on 1st pixel, eol every 8th, eof on 64th. 4 cycles with src_ready=0 between frames. done pulses once after the 128th pixel consumed. frames_done=2.
- Same stimulus, sink_ready toggled pseudo-randomly -> output pixel sequence identical to source order, no drops or duplicates; pix_out stable while stalled.
- num_frames=0, stop pulsed at pixel 20 of frame 3 -> frame 3 completes (64 px), done pulses, frames_done=3, no further src_ready.
- Source gaps (src_valid low 3 of 4 cycles) -> row/col/eof correct; eof still at the 64th accepted pixel.
- rst_n low at pixel 30 of frame 1, then restart -> all outputs at reset values; next run sof on first pixel, row=col=0.
- start pulsed while busy, stop pulsed in IDLE -> no state change.
